// File: rtl/jtframe_cen_pkg.sv
// Shared ratio constants and helpers for the jtframe fractional clock-enable generators.
package jtframe_cen_pkg;

  localparam int CEN_DIVS_MAX = 8;

  // 48 MHz master clock ratios used by the sound-chip wrappers
  localparam int CEN_48M_3P57_NUM = 105;   // 3.579545 MHz
  localparam int CEN_48M_3P57_DEN = 1408;
  localparam int CEN_48M_1P79_NUM = 105;   // 1.789773 MHz, needs W >= 12
  localparam int CEN_48M_1P79_DEN = 2816;
  localparam int CEN_48M_6M_NUM   = 1;
  localparam int CEN_48M_6M_DEN   = 8;
  localparam int CEN_48M_4M_NUM   = 1;
  localparam int CEN_48M_4M_DEN   = 12;

  function automatic bit cen_cfg_ok(int unsigned num, int unsigned den);
    return (den != 0) && (num <= den);
  endfunction

endpackage

// File: rtl/jtframe_cen_div.sv
// Power-of-two sub-rate decode: cen[k] fires on every 2^k-th base pulse.
module jtframe_cen_div #(
  parameter int DIVS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            base,
  output logic [DIVS-1:0] cen
);

  generate
    if (DIVS == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (rst) cen <= '0;
        else     cen <= base & ~clr;
      end
    end else begin : g_multi
      logic [DIVS-2:0] ph;
      logic [DIVS-1:0] dec;

      assign dec[0] = base;
      // decode uses ph before this pulse increments it
      for (genvar k = 1; k < DIVS; k++) begin : g_dec
        assign dec[k] = base & (&ph[k-1:0]);
      end

      always_ff @(posedge clk) begin
        if (rst || clr) ph <= '0;
        else if (base)  ph <= ph + 1'b1;
      end

      always_ff @(posedge clk) begin
        if (rst) cen <= '0;
        else     cen <= dec;
      end
    end
  endgenerate

endmodule

// File: rtl/jtframe_frac_cen.sv
// Fractional clock enable: base rate clk*num/den plus halved sub-rates,
// with run-time ratio reload and accumulator corruption recovery.
module jtframe_frac_cen
  import jtframe_cen_pkg::*;
#(
  parameter int W    = 11,
  parameter int NUM  = 105,
  parameter int DEN  = 1408,
  parameter int DIVS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            cfg_we,
  input  logic [W-1:0]    cfg_num,
  input  logic [W-1:0]    cfg_den,
  output logic            cfg_ack,
  output logic            cfg_err,
  output logic [DIVS-1:0] cen
);

  logic [W:0]   cnt;
  logic [W-1:0] num, den;
  logic [W:0]   next, lim;
  logic         cfg_ok, corrupt, base, clr;

  assign next   = cnt + {1'b0, num};
  assign lim    = {1'b0, den} + {1'b0, num};
  assign cfg_ok = cen_cfg_ok(int'(cfg_num), int'(cfg_den));

  // A load always wins over accumulation, so a pending pulse is dropped.
  always_comb begin
    base    = 1'b0;
    clr     = 1'b0;
    corrupt = 1'b0;
    if (!rst) begin
      if (cfg_we) begin
        clr = cfg_ok;
      end else if (!hold) begin
        if (cnt >= lim) begin
          corrupt = 1'b1;
          clr     = 1'b1;
        end else if (next >= {1'b0, den}) begin
          base = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      num     <= W'(NUM);
      den     <= W'(DEN);
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
      if (cfg_we) begin
        if (cfg_ok) begin
          num     <= cfg_num;
          den     <= cfg_den;
          cnt     <= '0;
          cfg_ack <= 1'b1;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (!hold) begin
        if (corrupt) begin
          cnt     <= '0;
          cfg_err <= 1'b1;
        end else if (base) begin
          cnt <= next - {1'b0, den};
        end else begin
          cnt <= next;
        end
      end
    end
  end

  jtframe_cen_div #(.DIVS(DIVS)) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .base (base),
    .cen  (cen)
  );

endmodule

// File: tb/tb_jtframe_frac_cen.sv
// Scoreboard bench: pulse k of cen[0] is expected at step n when floor(n*num/den) steps up.
module tb_jtframe_frac_cen;

  localparam int W    = 11;
  localparam int NUM  = 105;
  localparam int DEN  = 1408;
  localparam int DIVS = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1, hold = 1'b0, cfg_we = 1'b0;
  logic [W-1:0]    cfg_num = '0, cfg_den = '0;
  logic            cfg_ack, cfg_err;
  logic [DIVS-1:0] cen;

  always #5 clk = ~clk;

  jtframe_frac_cen #(.W(W), .NUM(NUM), .DEN(DEN), .DIVS(DIVS)) dut (
    .clk     (clk),
    .rst     (rst),
    .hold    (hold),
    .cfg_we  (cfg_we),
    .cfg_num (cfg_num),
    .cfg_den (cfg_den),
    .cfg_ack (cfg_ack),
    .cfg_err (cfg_err),
    .cen     (cen)
  );

  typedef struct packed {
    logic [DIVS-1:0] cen;
    logic            ack;
    logic            err;
  } exp_t;

  exp_t q[$];
  int   checks = 0, fails = 0;
  int   c0 = 0, c1 = 0;
  bit   counting = 1'b0;

  // reference: ratio plus number of accumulation steps since the last clear
  longint m_num = NUM, m_den = DEN, m_n = 0;

  function automatic exp_t model_step(bit r, bit h, bit we, longint cn, longint cd);
    exp_t e;
    longint p1, p0;
    e = '0;
    if (r) begin
      m_n = 0; m_num = NUM; m_den = DEN;
    end else if (we) begin
      if (cd != 0 && cn <= cd) begin
        m_num = cn; m_den = cd; m_n = 0; e.ack = 1'b1;
      end else begin
        e.err = 1'b1;
      end
    end else if (!h) begin
      m_n++;
      p1 = (m_n * m_num) / m_den;
      p0 = ((m_n - 1) * m_num) / m_den;
      if (p1 > p0)
        for (int k = 0; k < DIVS; k++)
          e.cen[k] = ((p1 % (longint'(1) << k)) == 0);
    end
    return e;
  endfunction

  task automatic cyc(bit r, bit h, bit we, int cn, int cd);
    @(negedge clk);
    rst = r; hold = h; cfg_we = we;
    cfg_num = W'(cn); cfg_den = W'(cd);
    q.push_back(model_step(r, h, we, cn, cd));
    @(posedge clk);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic corrupt();
    exp_t e;
    @(negedge clk);
    rst = 0; hold = 0; cfg_we = 0;
    force dut.cnt = 12'd2047;
    #1 release dut.cnt;
    e = '0; e.err = 1'b1; m_n = 0;
    q.push_back(e);
    @(posedge clk);
  endtask

  task automatic check_int(string name, int act, int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // monitor: one registered output set per edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({cen, cfg_ack, cfg_err} !== e) begin
          fails++;
          $display("FAIL outputs @%0t: cen=%b ack=%b err=%b expected cen=%b ack=%b err=%b",
                   $time, cen, cfg_ack, cfg_err, e.cen, e.ack, e.err);
        end
        if (counting) begin
          c0 += int'(cen[0]);
          c1 += int'(cen[1]);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);

    // long-run rate with default ratio
    counting = 1'b1;
    run(1408 * 20);
    #2 counting = 1'b0;
    check_int("cen0_count", c0, 2100);
    check_int("cen1_count", c1, 1050);

    // hold mid-stream
    run(37);
    for (int i = 0; i < 100; i++) cyc(0, 1, 0, 0, 0);
    run(300);

    // reset during a load discards it
    cyc(1, 0, 1, 3, 4);
    run(20);

    // forced corruption with defaults
    cyc(1, 0, 0, 0, 0);
    run(5);
    corrupt();
    run(30);

    // rejected loads
    cyc(0, 0, 1, 5, 0);
    run(200);
    cyc(0, 0, 1, 9, 8);
    run(200);

    // 1/4 ratio across the divider chain
    cyc(0, 0, 1, 1, 4);
    run(70);

    // load colliding with a pending base pulse, then num=den
    cyc(1, 0, 0, 0, 0);
    run(13);
    cyc(0, 0, 1, 7, 7);
    run(20);

    // randomized mix of holds, loads (some illegal) and resets
    for (int i = 0; i < 3000; i++) begin
      int  sel = $urandom_range(0, 199);
      bit  r   = (sel == 0);
      bit  we  = (sel >= 1 && sel <= 4);
      bit  h   = (sel >= 5 && sel <= 24);
      int  cn  = $urandom_range(0, 40);
      int  cd  = $urandom_range(0, 40);
      cyc(r, h, we, cn, cd);
    end

    @(negedge clk);
    rst = 0; hold = 0; cfg_we = 0;
    @(negedge clk);
    check_int("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
